// File: rtl/vga_vblank_arbiter.sv
// Display-RAM write scheduler for the 640x480 monitor path.
// Grants one of two writers (0: waveform samples, 1: menu overlay) only
// inside the vertical blanking window, round-robin when both request, and
// revokes a held grant before active video resumes. Also keeps a frame
// counter and a blink flag for overlay animation.
//
// Handshake: req[n] is a level held by writer n until its transfer is
// done; grant[n] is registered and one-hot. Writer n may write on every
// cycle grant[n] is high. When writer n drops req[n], grant[n] falls on
// the next edge and a one-cycle dead gap follows before any new grant.
// A grant taken away while req[n] is still high is flagged by a
// one-cycle abort pulse coincident with grant falling.
module vga_vblank_arbiter #(
    parameter int VBLANK_LINES = 45,
    parameter int GUARD_LINES  = 2,
    parameter int FRAME_W      = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vblank,
    input  logic               line_tick,
    input  logic [1:0]         req,
    output logic [1:0]         grant,
    output logic               abort,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               blink,
    output logic [2:0]         dbg_state
);

    localparam int BL_W = $clog2(VBLANK_LINES + 1);
    localparam int BK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BL_W-1:0] BL_MAX   = BL_W'(VBLANK_LINES);
    localparam logic [BL_W-1:0] BL_LIMIT = BL_W'(VBLANK_LINES - GUARD_LINES);
    localparam logic [BK_W-1:0] BK_LAST  = BK_W'(BLINK_FRAMES - 1);

    typedef enum logic [2:0] {
        ACTIVE     = 3'd0,
        BLANK_IDLE = 3'd1,
        GRANT0     = 3'd2,
        GRANT1     = 3'd3,
        CLOSED     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               vblank_d_q;
    logic               rr_q, rr_d;
    logic [BL_W-1:0]    bl_q, bl_d;
    logic [1:0]         grant_q, grant_d;
    logic               abort_q, abort_d;
    logic               busy_q, busy_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [BK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;

    logic frame_start;
    logic window_open;
    logic cur;
    logic cur_req;

    assign frame_start = vblank & ~vblank_d_q;
    assign window_open = vblank & (bl_q < BL_LIMIT);

    // Frame counter, blink divider and blank-line counter.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        bl_d        = bl_q;
        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            bl_d        = '0;
            if (blink_cnt_q == BK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end else if ((state_q != ACTIVE) && line_tick && (bl_q < BL_MAX)) begin
            bl_d = bl_q + 1'b1;
        end
    end

    // Arbiter next state; grant/abort/busy are computed for the next cycle.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = 2'b00;
        abort_d = 1'b0;
        cur     = (state_q == GRANT1);
        cur_req = req[cur];
        case (state_q)
            ACTIVE: begin
                if (frame_start) state_d = BLANK_IDLE;
            end
            BLANK_IDLE: begin
                if (!vblank) begin
                    state_d = ACTIVE;
                end else if (!window_open) begin
                    state_d = CLOSED;
                end else if (req == 2'b01 || (req == 2'b11 && !rr_q)) begin
                    state_d = GRANT0;
                    grant_d = 2'b01;
                end else if (req == 2'b10 || (req == 2'b11 && rr_q)) begin
                    state_d = GRANT1;
                    grant_d = 2'b10;
                end
            end
            GRANT0, GRANT1: begin
                if (!vblank) begin
                    // Early end of blanking: revoke, flag if still wanted.
                    state_d = ACTIVE;
                    abort_d = cur_req;
                    rr_d    = ~cur;
                end else if (!cur_req) begin
                    state_d = BLANK_IDLE;
                    rr_d    = ~cur;
                end else if (!window_open) begin
                    state_d = CLOSED;
                    abort_d = 1'b1;
                    rr_d    = ~cur;
                end else begin
                    grant_d = cur ? 2'b10 : 2'b01;
                end
            end
            CLOSED: begin
                if (!vblank) state_d = ACTIVE;
            end
            default: begin
                state_d = ACTIVE;
            end
        endcase
        busy_d = |grant_d;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACTIVE;
            vblank_d_q  <= 1'b1;
            rr_q        <= 1'b0;
            bl_q        <= '0;
            grant_q     <= 2'b00;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            vblank_d_q  <= vblank;
            rr_q        <= rr_d;
            bl_q        <= bl_d;
            grant_q     <= grant_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign grant     = grant_q;
    assign abort     = abort_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign blink     = blink_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vga_vblank_arbiter.sv
// Directed bench for vga_vblank_arbiter with default parameters
// (45 blank lines, 2 guard lines, 8-bit frame counter, blink every 30).
module tb_vga_vblank_arbiter;

    localparam logic [2:0] S_ACTIVE = 3'd0;
    localparam logic [2:0] S_BLANK  = 3'd1;
    localparam logic [2:0] S_CLOSED = 3'd4;

    logic       clk;
    logic       rst;
    logic       vblank;
    logic       line_tick;
    logic [1:0] req;
    logic [1:0] grant;
    logic       abort;
    logic       busy;
    logic [7:0] frame_cnt;
    logic       blink;
    logic [2:0] dbg_state;

    int errors = 0;
    int checks = 0;

    vga_vblank_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .vblank    (vblank),
        .line_tick (line_tick),
        .req       (req),
        .grant     (grant),
        .abort     (abort),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .blink     (blink),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // advance n clock edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        line_tick = 1'b1;
        step(1);
        line_tick = 1'b0;
        step(2);
    endtask

    initial begin
        rst       = 1'b1;
        vblank    = 1'b1;
        line_tick = 1'b0;
        req       = 2'b00;
        step(3);
        check("rst_grant", grant, 2'b00);
        check("rst_abort", abort, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame", frame_cnt, 8'd0);
        check("rst_blink", blink, 1'b0);
        check("rst_state", dbg_state, S_ACTIVE);

        // Release with vblank already high: not a frame start.
        rst = 1'b0;
        req = 2'b01;
        step(5);
        check("no_grant_after_release", grant, 2'b00);
        check("no_frame_after_release", frame_cnt, 8'd0);
        vblank = 1'b0;
        step(3);
        check("no_grant_active", grant, 2'b00);

        // Frame 1: both request, rr=0 -> writer 0 first.
        vblank = 1'b1;
        req    = 2'b11;
        step(1);
        check("frame1_cnt", frame_cnt, 8'd1);
        check("frame1_decision_grant", grant, 2'b00);
        check("frame1_state", dbg_state, S_BLANK);
        step(1);
        check("grant0_first", grant, 2'b01);
        check("grant0_busy", busy, 1'b1);

        // Writer 0 releases: dead cycle, then writer 1.
        req = 2'b10;
        step(1);
        check("dead_cycle_grant", grant, 2'b00);
        check("dead_cycle_abort", abort, 1'b0);
        check("dead_cycle_busy", busy, 1'b0);
        step(1);
        check("grant1_after_dead", grant, 2'b10);

        // Writer 1 releases, writer 0 takes the bus and holds through guard.
        req = 2'b01;
        step(1);
        check("release1_grant", grant, 2'b00);
        step(1);
        check("grant0_again", grant, 2'b01);
        for (int i = 0; i < 42; i++) tick();
        check("grant_held_42_lines", grant, 2'b01);
        check("no_abort_42_lines", abort, 1'b0);
        line_tick = 1'b1;
        step(1);
        line_tick = 1'b0;
        check("grant_cycle_after_43rd", grant, 2'b01);
        step(1);
        check("guard_grant_drop", grant, 2'b00);
        check("guard_abort_pulse", abort, 1'b1);
        check("guard_busy", busy, 1'b0);
        check("guard_state", dbg_state, S_CLOSED);
        step(1);
        check("guard_abort_one_cycle", abort, 1'b0);
        tick();
        tick();
        check("closed_no_grant", grant, 2'b00);

        // Frame 2: rr moved to writer 1; writer 0 never granted in ACTIVE.
        vblank = 1'b0;
        req    = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("active_ignores_req", grant, 2'b00);
        end
        vblank = 1'b1;
        step(1);
        check("frame2_cnt", frame_cnt, 8'd2);
        check("frame2_decision_grant", grant, 2'b00);
        step(1);
        check("rr_fair_grant1", grant, 2'b10);

        // vblank falls early during GRANT1.
        vblank = 1'b0;
        step(1);
        check("early_fall_grant", grant, 2'b00);
        check("early_fall_abort", abort, 1'b1);
        check("early_fall_busy", busy, 1'b0);
        check("early_fall_state", dbg_state, S_ACTIVE);
        step(1);
        check("early_fall_abort_one", abort, 1'b0);
        req = 2'b00;

        // Frames 3..256: blink toggles every 30 frames, counter wraps.
        for (int f = 3; f <= 256; f++) begin
            vblank = 1'b1;
            step(2);
            vblank = 1'b0;
            step(2);
            if (f == 29) check("blink_f29", blink, 1'b0);
            if (f == 30) check("blink_f30", blink, 1'b1);
            if (f == 59) check("blink_f59", blink, 1'b1);
            if (f == 60) check("blink_f60", blink, 1'b0);
            if (f == 255) check("frame_255", frame_cnt, 8'd255);
            if (f == 256) check("frame_wrap", frame_cnt, 8'd0);
        end

        // Async reset mid-grant: grant drops immediately, no abort.
        vblank = 1'b1;
        req    = 2'b01;
        step(2);
        check("pre_reset_grant", grant, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_grant", grant, 2'b00);
        check("async_rst_abort", abort, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_frame", frame_cnt, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_vblank_arbiter.md
Name: vga_vblank_arbiter

Overview:
- Schedules display-RAM write access for the 640x480 VGA monitor path. Writes are only permitted during vertical blanking, so scanout reads are never disturbed.
- Arbitrates round-robin between two writers: requester 0 is the waveform sample writer and requester 1 is the menu/parameter overlay writer.
- Revokes any grant before active video resumes.
- Also maintains a frame counter and a blink flag for cursor/overlay animation.
- Sits between vga_driver, which supplies blanking/line timing, and the display-RAM write mux.

Parameters:
- VBLANK_LINES, 45, number of line_tick pulses in one vertical blanking interval.
- GUARD_LINES, 2, final blank lines in which no new grant is issued and any held grant is revoked.
- FRAME_W, 8, width of frame_cnt.
- BLINK_FRAMES, 30, number of frames between blink toggles.

Ports:
- clk, input, 1, system clock 50 MHz.
- rst, input, 1, asynchronous active-high reset.
- vblank, input, 1, vertical blanking level from vga_driver, synchronous to clk.
- line_tick, input, 1, one-cycle pulse at each horizontal sync start.
- req, input, 2, write request per requester; level, held until the transfer completes.
- grant, output, 2, one-hot write grant; 2'b00 means no writer.
- abort, output, 1, one-cycle pulse when a grant is forcibly revoked.
- busy, output, 1, high while any grant is asserted.
- frame_cnt, output, FRAME_W, frames elapsed; wraps.
- blink, output, 1, toggles every BLINK_FRAMES frames.

Behaviour:
- Reset (async, rst=1):
  - grant=0, abort=0, busy=0, frame_cnt=0, blink=0.
  - State ACTIVE, rr pointer=0 (requester 0 preferred first), blank line counter bl=0.
  - Registered vblank_d=1, so vblank already high at reset release is not a frame start; no grants until the next detected rising edge.
- Frame start: vblank=1 and vblank_d=0 (rising edge).
  - frame_cnt increments modulo 2^FRAME_W.
  - Blink counter increments. On reaching BLINK_FRAMES-1 it clears and blink toggles.
  - bl clears to 0.
- Blank line counter:
  - In blank states, each line_tick increments bl, saturating at VBLANK_LINES.
  - Window open = (bl < VBLANK_LINES-GUARD_LINES) and vblank=1.
- FSM states: ACTIVE, BLANK_IDLE, GRANT0, GRANT1, CLOSED.
  - ACTIVE:
    - Go to BLANK_IDLE on the vblank rising edge.
    - grant=0.
  - BLANK_IDLE:
    - If the window is open and any req is set, select a requester.
      - Only one req set: that requester wins.
      - Both set: the requester equal to rr wins.
    - Go to GRANT0 or GRANT1. grant is registered and appears the cycle after the decision cycle.
    - If the window is closed, go to CLOSED.
  - GRANTn:
    - grant[n]=1, busy=1.
    - If req[n] drops: grant drops next cycle, rr becomes 1-n, go to BLANK_IDLE. There is a mandatory one-cycle dead cycle before any new grant.
    - If the window closes while req[n] is still high: go to CLOSED, grant drops, and abort pulses in the same cycle grant drops. rr becomes 1-n.
    - If req[n] drops in the same cycle the window closes: normal release, no abort.
  - CLOSED:
    - grant=0, no new grants.
    - Go to ACTIVE when vblank=0.
  - Any state: vblank=0 (early fall) forces ACTIVE the next cycle.
    - A held grant drops and abort pulses.
    - bl holds its value until the next frame start.
- Requests in ACTIVE are ignored (no latching). Requesters must hold req.
- grant is always one-hot or zero. Never 2'b11.
- line_tick outside blank states is ignored.
- rst asserted mid-grant: grant drops immediately (async), with no abort pulse.

Test Plan:
- Reset with vblank=1, then release; drive req=2'b01 -> grant stays 0 until vblank falls and rises again; frame_cnt=1 after that edge.
- After a vblank rise, req=2'b11 -> grant=2'b01 one cycle later. Drop req[0] -> grant=0 for one cycle, then grant=2'b10.
- req[0] held through the guard (VBLANK_LINES=45, GUARD_LINES=2) -> grant drops on the cycle after the 43rd line_tick, abort=1 for exactly one cycle; no further grant in that frame.
- Next frame, req=2'b11 again -> grant=2'b10 first (rr fairness); grant=2'b01 is never asserted during ACTIVE.
- vblank falls during GRANT1 -> grant=0 and abort pulse; state ACTIVE, busy=0.
- Run 60 frames -> blink toggles at frame 30 and frame 60; FRAME_W=8 counter wraps 255->0 after 256 frames.
